// File: rtl/fpmul_arbiter.sv
// Round-robin arbiter/sequencer sharing one multi-cycle FP multiplier core among NREQ requesters.
// Latency: core latency + 3 cycles per transaction; req is level-held until ack, later req changes wait for IDLE.
`timescale 1ns/1ps
module fpmul_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [32*NREQ-1:0]   a_in,
  input  logic [32*NREQ-1:0]   b_in,
  output logic [NREQ-1:0]      ack,
  output logic [31:0]          result,
  output logic                 err,
  output logic [NREQ-1:0]      grant,
  output logic                 busy,
  output logic                 core_start,
  output logic [31:0]          core_a,
  output logic [31:0]          core_b,
  input  logic                 core_done,
  input  logic [31:0]          core_result
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   ptr, idx, win_idx, j;
  logic            win_vld;
  logic [CW-1:0]   wd_cnt;
  logic            wd_hit;
  logic            err_flag;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    win_idx = '0;
    win_vld = 1'b0;
    j       = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      j = IW'((int'(ptr) + off) % NREQ);
      if (req[j]) begin
        win_idx = j;
        win_vld = 1'b1;
      end
    end
  end

  assign wd_hit = (wd_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (win_vld) state_nxt = ISSUE;
      ISSUE:     state_nxt = WAIT_BUSY;
      // done still high here is left over from the idle period, not completion
      WAIT_BUSY: if (wd_hit) state_nxt = RESP;
                 else if (!core_done) state_nxt = WAIT_DONE;
      WAIT_DONE: if (core_done || wd_hit) state_nxt = RESP;
      RESP:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    core_start = (state == ISSUE);
    ack        = (state == RESP) ? grant : '0;
    err        = (state == RESP) && err_flag;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr      <= '0;
      idx      <= '0;
      grant    <= '0;
      core_a   <= '0;
      core_b   <= '0;
      result   <= '0;
      wd_cnt   <= '0;
      err_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: if (win_vld) begin
          grant  <= NREQ'(1) << win_idx;
          idx    <= win_idx;
          core_a <= a_in[{win_idx, 5'b0} +: 32];
          core_b <= b_in[{win_idx, 5'b0} +: 32];
          wd_cnt <= '0;
        end
        WAIT_BUSY, WAIT_DONE: begin
          // completion on the timeout cycle takes priority over the abort
          if (state == WAIT_DONE && core_done) begin
            result <= core_result;
          end else if (wd_hit) begin
            result   <= QNAN;
            err_flag <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        RESP: begin
          grant    <= '0;
          err_flag <= 1'b0;
          ptr      <= (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpmul_arbiter.sv
// Bench for fpmul_arbiter: transaction-level timing model plus behavioural FP core, checked every cycle.
`timescale 1ns/1ps
module tb_fpmul_arbiter;
  localparam int N = 4;
  localparam int T = 16;

  logic         clk = 1'b0, rst = 1'b0;
  logic [N-1:0] req = '0;
  logic [127:0] a_in = '0, b_in = '0;
  logic [N-1:0] ack, grant;
  logic [31:0]  result, core_a, core_b, core_result;
  logic         err, busy, core_start;
  logic         core_done = 1'b1;

  int tests = 0, fails = 0, cyc = 0;
  int S = 0, L = 1;          // core: done stays high S cycles after start, then low L cycles
  bit core_run = 0;
  int t0 = 0, last_start = 0;

  bit          m_busy = 0, m_err = 0;
  int          m_ptr = 0, m_win = 0, m_g = 0, m_ack = 0;
  logic [31:0] m_res = '0, m_last = '0, m_a = '0, m_b = '0;

  fpmul_arbiter #(.NREQ(N), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .ack(ack), .result(result), .err(err), .grant(grant), .busy(busy),
    .core_start(core_start), .core_a(core_a), .core_b(core_b),
    .core_done(core_done), .core_result(core_result)
  );

  always #5 clk = ~clk;

  // Normal-operand single-precision multiply with truncation.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [9:0]  e;
    logic [22:0] m;
    if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {a[31] ^ b[31], 31'd0};
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
    if (p[47]) begin m = p[46:24]; e = e + 10'd1; end
    else       m = p[45:23];
    return {a[31] ^ b[31], e[7:0], m};
  endfunction

  assign core_result = fmul(core_a, core_b);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Core model, driven mid-cycle.
  always @(negedge clk) begin
    if (!rst) core_run = 0;
    else if (core_start) begin core_run = 1; t0 = cyc; last_start = cyc; end
    core_done = !(core_run && cyc >= t0 + 1 + S && cyc <= t0 + S + L);
  end

  // Transaction model: winner, ack cycle, error and product decided at grant time.
  always @(posedge clk) begin
    int c, k;
    c = cyc;
    if (!rst) begin
      m_busy = 0; m_ptr = 0; m_last = '0; m_a = '0; m_b = '0;
    end else if (m_busy) begin
      if (c == m_ack) begin m_busy = 0; m_last = m_res; m_ptr = (m_win + 1) % N; end
    end else if (req != '0) begin
      k = 0;
      while (!req[(m_ptr + k) % N]) k++;
      m_win = (m_ptr + k) % N;
      m_g = c;
      m_a = a_in[32*m_win +: 32];
      m_b = b_in[32*m_win +: 32];
      if (S + L + 1 <= T) begin m_ack = c + 3 + S + L; m_err = 0; m_res = fmul(m_a, m_b); end
      else                 begin m_ack = c + 2 + T;     m_err = 1; m_res = 32'h7FC00000; end
      m_busy = 1;
    end
    cyc = c + 1;
  end

  always @(negedge clk) begin
    bit ac;
    if (rst) begin
      ac = m_busy && cyc == m_ack;
      check("ack", ack, ac ? (1 << m_win) : 0);
      check("grant", grant, m_busy ? (1 << m_win) : 0);
      check("busy", busy, m_busy);
      check("core_start", core_start, m_busy && cyc == m_g + 1);
      check("err", err, ac && m_err);
      check("result", result, ac ? m_res : m_last);
      check("core_a", core_a, m_a);
      check("core_b", core_b, m_b);
    end
  end

  task automatic wait_ack(input int idx, input logic [31:0] res, input bit e, input int lat);
    int n;
    n = 0;
    do begin @(negedge clk); #1; n++; end while (ack == '0 && n < 80);
    check("ack_idx", ack, 1 << idx);
    check("ack_result", result, res);
    check("ack_err", err, e);
    if (lat > 0) check("ack_latency", cyc - last_start, lat);
  endtask

  task automatic check_reset();
    check("rst_ack", ack, 0);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_start", core_start, 0);
    check("rst_err", err, 0);
    check("rst_result", result, 0);
    check("rst_core_a", core_a, 0);
    check("rst_core_b", core_b, 0);
  endtask

  initial begin
    a_in = {32'h3FC00000, 32'h40400000, 32'h40000000, 32'h3F800000};
    b_in = {32'h40000000, 32'h3F000000, 32'h40400000, 32'h40000000};
    repeat (2) @(negedge clk);
    #1 check_reset();
    rst = 1'b1;

    // contention from ptr=0
    S = 1; L = 2; req = 4'hF;
    wait_ack(0, 32'h40000000, 0, 5);
    wait_ack(1, 32'h40C00000, 0, 5);
    wait_ack(2, 32'h3FC00000, 0, 5);
    wait_ack(3, 32'h40400000, 0, 5);
    wait_ack(0, 32'h40000000, 0, 5);
    req = 4'h0;

    // single request
    S = 0; L = 3; req = 4'b0001;
    wait_ack(0, 32'h40000000, 0, 5);
    req = 4'h0;

    // pointer fairness: after serving 1, ptr=2 so 0 goes before 1
    S = 0; L = 1; req = 4'b0010;
    wait_ack(1, 32'h40C00000, 0, 0);
    req = 4'b0011;
    wait_ack(0, 32'h40000000, 0, 0);
    wait_ack(1, 32'h40C00000, 0, 0);
    req = 4'h0;

    // stale done held high after start
    S = 2; L = 3; req = 4'b1000;
    wait_ack(3, 32'h40400000, 0, 7);
    req = 4'h0;

    // done never drops / never rises
    S = 1000; L = 1; req = 4'b0001;
    wait_ack(0, 32'h7FC00000, 1, 17);
    req = 4'h0;
    S = 0; L = 1000; req = 4'b0010;
    wait_ack(1, 32'h7FC00000, 1, 17);
    req = 4'h0;

    // one cycle past the boundary, then exactly on it
    S = 5; L = 11; req = 4'b0100;
    wait_ack(2, 32'h7FC00000, 1, 17);
    req = 4'h0;
    S = 5; L = 10; req = 4'b1000;
    wait_ack(3, 32'h40400000, 0, 17);
    req = 4'h0;
    S = 0; L = 2; req = 4'b0001;
    wait_ack(0, 32'h40000000, 0, 4);
    req = 4'h0;

    // reset while in WAIT_DONE with ptr=1
    S = 0; L = 10; req = 4'b0100;
    repeat (6) @(negedge clk);
    #1 rst = 1'b0;
    #1 check_reset();
    S = 0; L = 2; req = 4'b1001;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    wait_ack(0, 32'h40000000, 0, 4);
    req = 4'h0;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
